// File: rtl/mnist_layer_sequencer.sv
// Layer sequencer for the 784-input MAC: per neuron clear, stream pixel/weight
// addresses, capture the sum, track a signed argmax and report the winning class.
//   state   | meaning
//   S_IDLE  | waiting for start
//   S_CLEAR | one-cycle accumulator clear, address counters reloaded
//   S_ACCUM | one mac_en per non-stalled cycle, NUM_INPUTS beats per neuron
//   S_WAIT  | waiting for the MAC final sum
//   S_DONE  | one-cycle done pulse, class outputs already valid
module mnist_layer_sequencer #(
    parameter int NUM_INPUTS  = 784,
    parameter int NUM_NEURONS = 10,
    parameter int ACC_W       = 26,
    parameter int PIX_AW      = 10,
    parameter int WGT_AW      = 13,
    parameter int IDX_W       = 4
) (
    input  logic              clk,
    input  logic              GlobalReset,
    input  logic              start,
    input  logic              stall,
    input  logic              acc_valid,
    input  logic [ACC_W-1:0]  acc_value,
    output logic              busy,
    output logic              done,
    output logic              mac_clr,
    output logic              mac_en,
    output logic              mac_last,
    output logic [PIX_AW-1:0] pix_addr,
    output logic [WGT_AW-1:0] wgt_addr,
    output logic [IDX_W-1:0]  neuron_idx,
    output logic              result_valid,
    output logic [ACC_W-1:0]  result_value,
    output logic [IDX_W-1:0]  class_out,
    output logic [ACC_W-1:0]  class_score
);

    localparam logic [PIX_AW-1:0] LAST_PIX    = PIX_AW'(NUM_INPUTS - 1);
    localparam logic [IDX_W-1:0]  LAST_NEURON = IDX_W'(NUM_NEURONS - 1);
    localparam logic [WGT_AW-1:0] BASE_STEP   = WGT_AW'(NUM_INPUTS);

    typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_ACCUM, S_WAIT, S_DONE} state_t;

    state_t             state_q, state_d;
    logic [WGT_AW-1:0]  base_q;
    logic [ACC_W-1:0]   best_q, best_d;
    logic [IDX_W-1:0]   best_idx_q, best_idx_d;
    logic               rv_q;
    logic               take_new;
    logic               last_neuron;

    always_ff @(posedge clk) begin
        if (!GlobalReset) state_q <= S_IDLE;
        else              state_q <= state_d;
    end

    always_comb begin
        state_d  = state_q;
        mac_clr  = 1'b0;
        mac_en   = 1'b0;
        mac_last = 1'b0;
        done     = 1'b0;
        case (state_q)
            S_IDLE:  if (start) state_d = S_CLEAR;
            S_CLEAR: begin
                mac_clr = 1'b1;
                state_d = S_ACCUM;
            end
            S_ACCUM: if (!stall) begin
                mac_en = 1'b1;
                if (pix_addr == LAST_PIX) begin
                    mac_last = 1'b1;
                    state_d  = S_WAIT;
                end
            end
            S_WAIT:  if (acc_valid) state_d = last_neuron ? S_DONE : S_CLEAR;
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        // the state register still holds its old value during the reset cycle
        if (!GlobalReset) begin
            mac_clr  = 1'b0;
            mac_en   = 1'b0;
            mac_last = 1'b0;
            done     = 1'b0;
        end
    end

    assign busy         = (state_q != S_IDLE);
    assign result_valid = rv_q & GlobalReset;
    assign last_neuron  = (neuron_idx == LAST_NEURON);
    assign take_new     = (neuron_idx == '0) || ($signed(acc_value) > $signed(best_q));
    assign best_d       = take_new ? acc_value  : best_q;
    assign best_idx_d   = take_new ? neuron_idx : best_idx_q;

    always_ff @(posedge clk) begin
        if (!GlobalReset) begin
            pix_addr     <= '0;
            wgt_addr     <= '0;
            neuron_idx   <= '0;
            base_q       <= '0;
            best_q       <= '0;
            best_idx_q   <= '0;
            rv_q         <= 1'b0;
            result_value <= '0;
            class_out    <= '0;
            class_score  <= '0;
        end else begin
            rv_q <= 1'b0;
            case (state_q)
                S_IDLE: if (start) begin
                    neuron_idx <= '0;
                    base_q     <= '0;
                end
                S_CLEAR: begin
                    pix_addr <= '0;
                    wgt_addr <= base_q;
                end
                // the final beat leaves the addresses on the last input so wgt_addr never passes the table end
                S_ACCUM: if (!stall && (pix_addr != LAST_PIX)) begin
                    pix_addr <= pix_addr + 1'b1;
                    wgt_addr <= wgt_addr + 1'b1;
                end
                S_WAIT: if (acc_valid) begin
                    result_value <= acc_value;
                    rv_q         <= 1'b1;
                    best_q       <= best_d;
                    best_idx_q   <= best_idx_d;
                    // loading the class here makes it valid during the done pulse
                    if (last_neuron) begin
                        class_out   <= best_idx_d;
                        class_score <= best_d;
                    end else begin
                        neuron_idx <= neuron_idx + 1'b1;
                        base_q     <= base_q + BASE_STEP;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
